// File: rtl/c5_mult_pkg.sv
// rtl/c5_mult_pkg.sv - shared MULT_*/ALU_* function codes and multiplier state encodings
package c5_mult_pkg;

  localparam logic [3:0] MULT_NOTHING       = 4'd0;
  localparam logic [3:0] MULT_READ_LO       = 4'd1;
  localparam logic [3:0] MULT_READ_HI       = 4'd2;
  localparam logic [3:0] MULT_WRITE_LO      = 4'd3;
  localparam logic [3:0] MULT_WRITE_HI      = 4'd4;
  localparam logic [3:0] MULT_MULT          = 4'd5;
  localparam logic [3:0] MULT_SIGNED_MULT   = 4'd6;
  localparam logic [3:0] MULT_DIVIDE        = 4'd7;
  localparam logic [3:0] MULT_SIGNED_DIVIDE = 4'd8;

  localparam logic [3:0] ALU_NOTHING          = 4'd0;
  localparam logic [3:0] ALU_ADD              = 4'd1;
  localparam logic [3:0] ALU_SUBTRACT         = 4'd2;
  localparam logic [3:0] ALU_LESS_THAN        = 4'd3;
  localparam logic [3:0] ALU_LESS_THAN_SIGNED = 4'd4;
  localparam logic [3:0] ALU_OR               = 4'd5;
  localparam logic [3:0] ALU_AND              = 4'd6;
  localparam logic [3:0] ALU_XOR              = 4'd7;
  localparam logic [3:0] ALU_NOR              = 4'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } mult_state_t;

endpackage

// File: rtl/c5_adder.sv
// rtl/c5_adder.sv - add/subtract with carry-out; for subtract, sum_o[WIDTH] set means no borrow
module c5_adder #(
  parameter int WIDTH = 33
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             do_add_i,
  output logic [WIDTH:0]   sum_o
);

  logic [WIDTH:0] b_ext;

  assign b_ext = do_add_i ? {1'b0, b_i} : {1'b0, ~b_i};
  assign sum_o = {1'b0, a_i} + b_ext + {{WIDTH{1'b0}}, ~do_add_i};

endmodule

// File: rtl/c5_mult.sv
// rtl/c5_mult.sv - iterative 32x32 multiply / restoring divide unit with HI/LO registers
module c5_mult
  import c5_mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             I_clk,
  input  logic             I_reset,
  input  logic [WIDTH-1:0] I_a_in,
  input  logic [WIDTH-1:0] I_b_in,
  input  logic [3:0]       I_mult_func,
  output logic [WIDTH-1:0] O_c_mult,
  output logic             O_pause
);

  localparam int CW = $clog2(WIDTH) + 1;

  mult_state_t      state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             div_q, div_d, neg_q, neg_d, neg_rem_q, neg_rem_d;

  logic [WIDTH:0]     add_a, add_b;
  logic [WIDTH+1:0]   add_sum;
  logic [2*WIDTH-1:0] prod_neg;
  logic               is_signed, is_div;

  // Divide feeds {remainder, next dividend bit}; multiply feeds HI plus the gated multiplicand.
  assign add_a = div_q ? {hi_q, a_q[WIDTH-1]} : {1'b0, hi_q};
  assign add_b = div_q ? {1'b0, b_q} : (b_q[0] ? {1'b0, a_q} : '0);

  c5_adder #(.WIDTH(WIDTH + 1)) u_adder (
    .a_i      (add_a),
    .b_i      (add_b),
    .do_add_i (~div_q),
    .sum_o    (add_sum)
  );

  assign prod_neg = -{hi_q, lo_q};

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    a_d       = a_q;
    b_d       = b_q;
    div_d     = div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    is_signed = (I_mult_func == MULT_SIGNED_MULT) || (I_mult_func == MULT_SIGNED_DIVIDE);
    is_div    = (I_mult_func == MULT_DIVIDE) || (I_mult_func == MULT_SIGNED_DIVIDE);

    case (state_q)
      CALC: begin
        if (div_q) begin
          if (add_sum[WIDTH+1]) begin
            hi_d = add_sum[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b1};
          end else begin
            hi_d = {hi_q[WIDTH-2:0], a_q[WIDTH-1]};
            lo_d = {lo_q[WIDTH-2:0], 1'b0};
          end
          a_d = {a_q[WIDTH-2:0], 1'b0};
        end else begin
          hi_d = add_sum[WIDTH:1];
          lo_d = {add_sum[0], lo_q[WIDTH-1:1]};
          b_d  = {1'b0, b_q[WIDTH-1:1]};
        end
        count_d = count_q - 1'b1;
        if (count_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        if (div_q) begin
          if (neg_q)     lo_d = -lo_q;
          if (neg_rem_q) hi_d = -hi_q;
        end else if (neg_q) begin
          {hi_d, lo_d} = prod_neg;
        end
        state_d = IDLE;
      end
      default: ;
    endcase

    // Writes and new operations take effect from any state, aborting work in flight.
    case (I_mult_func)
      MULT_WRITE_LO: begin
        lo_d    = I_a_in;
        state_d = IDLE;
      end
      MULT_WRITE_HI: begin
        hi_d    = I_a_in;
        state_d = IDLE;
      end
      MULT_MULT, MULT_SIGNED_MULT, MULT_DIVIDE, MULT_SIGNED_DIVIDE: begin
        a_d       = (is_signed && I_a_in[WIDTH-1]) ? -I_a_in : I_a_in;
        b_d       = (is_signed && I_b_in[WIDTH-1]) ? -I_b_in : I_b_in;
        neg_d     = is_signed && (I_a_in[WIDTH-1] ^ I_b_in[WIDTH-1]);
        neg_rem_d = is_signed && is_div && I_a_in[WIDTH-1];
        div_d     = is_div;
        hi_d      = '0;
        lo_d      = '0;
        count_d   = CW'(WIDTH);
        state_d   = CALC;
      end
      default: ;
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      div_q     <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      a_q       <= a_d;
      b_q       <= b_d;
      div_q     <= div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  assign O_c_mult = (I_mult_func == MULT_READ_LO) ? lo_q :
                    (I_mult_func == MULT_READ_HI) ? hi_q : '0;
  assign O_pause  = ((I_mult_func == MULT_READ_LO) || (I_mult_func == MULT_READ_HI)) &&
                    (state_q != IDLE);

endmodule
